// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: operation mode
// encodings and the width of the shift counter.
package usr_pkg;

    localparam logic [2:0] MODE_HOLD = 3'd0;
    localparam logic [2:0] MODE_LOAD = 3'd1;
    localparam logic [2:0] MODE_SHL  = 3'd2;
    localparam logic [2:0] MODE_SHR  = 3'd3;
    localparam logic [2:0] MODE_ROL  = 3'd4;
    localparam logic [2:0] MODE_ROR  = 3'd5;
    localparam logic [2:0] MODE_INV  = 3'd6;
    localparam logic [2:0] MODE_RSVD = 3'd7;

    // One extra bit so the counter can represent WIDTH itself.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/usr_cell.sv
// One bit of the universal shift register: next-value mux feeding a flop
// with asynchronous active-low clear and synchronous active-low preset.
module usr_cell
    import usr_pkg::*;
#(
    parameter logic RESET_BIT  = 1'b0,
    parameter logic PRESET_BIT = 1'b1
) (
    input  logic       c,
    input  logic       clear,
    input  logic       preset,
    input  logic       en,
    input  logic [2:0] mode,
    input  logic       d,
    input  logic       from_lower,
    input  logic       from_upper,
    output logic       q
);

    logic nxt;

    // Reserved mode and en = 0 both fall through to hold.
    always_comb begin
        nxt = q;
        if (en) begin
            case (mode)
                MODE_LOAD:          nxt = d;
                MODE_SHL, MODE_ROL: nxt = from_lower;
                MODE_SHR, MODE_ROR: nxt = from_upper;
                MODE_INV:           nxt = ~q;
                default:            nxt = q;
            endcase
        end
    end

    always_ff @(posedge c or negedge clear) begin
        if (!clear) begin
            q <= RESET_BIT;
        end else if (!preset) begin
            q <= PRESET_BIT;
        end else begin
            q <= nxt;
        end
    end

endmodule

// File: rtl/universal_shift_register.sv
// WIDTH-bit register with hold/load/shift/rotate/invert modes, built from
// per-bit cells, plus a shift counter that pulses word_done every WIDTH shifts.
module universal_shift_register
    import usr_pkg::*;
#(
    parameter int               WIDTH        = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE  = '0,
    parameter logic [WIDTH-1:0] PRESET_VALUE = '1
) (
    input  logic                          c,
    input  logic                          clear,
    input  logic                          preset,
    input  logic                          en,
    input  logic [2:0]                    mode,
    input  logic [WIDTH-1:0]              d,
    input  logic                          si,
    output logic [WIDTH-1:0]              Q,
    output logic [WIDTH-1:0]              Qn,
    output logic                          so,
    output logic [cnt_width(WIDTH)-1:0]   count,
    output logic                          word_done
);

    localparam int            CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] q_r;
    logic             shift_op;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        logic from_lower;
        logic from_upper;

        // End bits take either the serial input or the wrapped-around bit.
        if (i == 0) begin : g_lsb
            assign from_lower = (mode == MODE_ROL) ? q_r[WIDTH-1] : si;
        end else begin : g_mid_lo
            assign from_lower = q_r[i-1];
        end

        if (i == WIDTH - 1) begin : g_msb
            assign from_upper = (mode == MODE_ROR) ? q_r[0] : si;
        end else begin : g_mid_hi
            assign from_upper = q_r[i+1];
        end

        usr_cell #(
            .RESET_BIT  (RESET_VALUE[i]),
            .PRESET_BIT (PRESET_VALUE[i])
        ) u_cell (
            .c          (c),
            .clear      (clear),
            .preset     (preset),
            .en         (en),
            .mode       (mode),
            .d          (d[i]),
            .from_lower (from_lower),
            .from_upper (from_upper),
            .q          (q_r[i])
        );
    end

    assign shift_op = en && ((mode == MODE_SHL) || (mode == MODE_SHR) ||
                             (mode == MODE_ROL) || (mode == MODE_ROR));

    always_ff @(posedge c or negedge clear) begin
        if (!clear) begin
            count     <= '0;
            word_done <= 1'b0;
        end else if (!preset) begin
            count     <= '0;
            word_done <= 1'b0;
        end else if (en && (mode == MODE_LOAD)) begin
            count     <= '0;
            word_done <= 1'b0;
        end else if (shift_op) begin
            if (count == CNT_LAST) begin
                count     <= '0;
                word_done <= 1'b1;
            end else begin
                count     <= count + 1'b1;
                word_done <= 1'b0;
            end
        end else begin
            word_done <= 1'b0;
        end
    end

    assign Q  = q_r;
    assign Qn = ~q_r;
    assign so = (mode == MODE_SHL) ? q_r[WIDTH-1] : q_r[0];

endmodule

// File: tb/tb_universal_shift_register.sv
// Bench for universal_shift_register (WIDTH=8): directed steps followed by
// randomized operations, checked against an arithmetic reference model.
module tb_universal_shift_register;

    localparam int         W   = 8;
    localparam logic [7:0] PRE = 8'hFF;
    localparam logic [7:0] RST = 8'h00;

    logic       c;
    logic       clear;
    logic       preset;
    logic       en;
    logic [2:0] mode;
    logic [7:0] d;
    logic       si;
    logic [7:0] Q;
    logic [7:0] Qn;
    logic       so;
    logic [3:0] count;
    logic       word_done;

    logic       clk_on;

    logic [7:0] m_q;
    int         m_cnt;
    logic       m_wd;
    logic [7:0] exp_q[$];

    int checks;
    int errors;

    universal_shift_register #(.WIDTH(W)) dut (
        .c         (c),
        .clear     (clear),
        .preset    (preset),
        .en        (en),
        .mode      (mode),
        .d         (d),
        .si        (si),
        .Q         (Q),
        .Qn        (Qn),
        .so        (so),
        .count     (count),
        .word_done (word_done)
    );

    // clock / reset block
    initial begin
        c      = 1'b0;
        clk_on = 1'b0;
    end
    always begin
        #5;
        if (clk_on) c = ~c;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic check_all(input string tag, input logic [7:0] exp_qv);
        logic exp_so;
        exp_so = (mode == 3'd2) ? exp_qv[7] : exp_qv[0];
        check({tag, ".Q"}, {24'b0, Q}, {24'b0, exp_qv});
        check({tag, ".Qn"}, {24'b0, Qn}, {24'b0, ~exp_qv});
        check({tag, ".so"}, {31'b0, so}, {31'b0, exp_so});
        check({tag, ".count"}, {28'b0, count}, m_cnt);
        check({tag, ".word_done"}, {31'b0, word_done}, {31'b0, m_wd});
    endtask

    task automatic model_clear();
        m_q   = RST;
        m_cnt = 0;
        m_wd  = 1'b0;
    endtask

    // Reference: applies the operation rules to the current inputs.
    task automatic model_step();
        bit shifted;
        shifted = 1'b0;
        if (!clear) begin
            model_clear();
        end else if (!preset) begin
            m_q   = PRE;
            m_cnt = 0;
            m_wd  = 1'b0;
        end else if (!en) begin
            m_wd = 1'b0;
        end else begin
            m_wd = 1'b0;
            case (mode)
                3'd1: begin m_q = d; m_cnt = 0; end
                3'd2: begin m_q = (m_q << 1) | {7'b0, si}; shifted = 1'b1; end
                3'd3: begin m_q = (m_q >> 1) | {si, 7'b0}; shifted = 1'b1; end
                3'd4: begin m_q = (m_q << 1) | (m_q >> 7); shifted = 1'b1; end
                3'd5: begin m_q = (m_q >> 1) | (m_q << 7); shifted = 1'b1; end
                3'd6: m_q = ~m_q;
                default: ;
            endcase
            if (shifted) begin
                m_cnt++;
                if (m_cnt == W) begin
                    m_cnt = 0;
                    m_wd  = 1'b1;
                end
            end
        end
    endtask

    // driver: one active edge, then compare against the scoreboard
    task automatic tick(input string tag);
        logic [7:0] e;
        model_step();
        exp_q.push_back(m_q);
        @(posedge c);
        #1;
        e = exp_q.pop_front();
        check_all(tag, e);
    endtask

    task automatic drive(input logic p, input logic e, input logic [2:0] m, input logic [7:0] dv, input logic s);
        preset = p;
        en     = e;
        mode   = m;
        d      = dv;
        si     = s;
    endtask

    logic [7:0] rol_seq [9];
    logic [7:0] shr_si;

    initial begin
        checks = 0;
        errors = 0;
        rol_seq = '{8'hA5, 8'h4B, 8'h96, 8'h2D, 8'h5A, 8'hB4, 8'h69, 8'hD2, 8'hA5};
        shr_si  = 8'b0100_1101;

        clear = 1'b0;
        drive(1'b1, 1'b0, 3'd0, 8'h00, 1'b0);
        model_clear();
        #2;
        check_all("reset_idle", m_q);
        check("reset_idle_const", {24'b0, Q}, 32'h00);

        clk_on = 1'b1;
        tick("reset_edge");
        #2 clear = 1'b1;

        drive(1'b0, 1'b0, 3'd1, 8'h3C, 1'b0);
        tick("preset");
        check("preset_const", {24'b0, Q}, 32'hFF);

        drive(1'b1, 1'b1, 3'd1, 8'hA5, 1'b0);
        tick("load_a5");
        check("rol_seq0", {24'b0, Q}, {24'b0, rol_seq[0]});
        mode = 3'd4;
        for (int i = 1; i <= 8; i++) begin
            tick("rol");
            check($sformatf("rol_seq%0d", i), {24'b0, Q}, {24'b0, rol_seq[i]});
        end
        check("rol_done_const", {31'b0, word_done}, 32'h1);
        mode = 3'd0;
        tick("after_rol");

        drive(1'b1, 1'b1, 3'd1, 8'h00, 1'b0);
        tick("load_00");
        mode = 3'd3;
        for (int i = 0; i < 8; i++) begin
            si = shr_si[i];
            tick("shr");
        end
        check("shr_const", {24'b0, Q}, 32'h4D);
        mode = 3'd0;
        tick("after_shr");

        drive(1'b1, 1'b1, 3'd1, 8'h0F, 1'b0);
        tick("load_0f");
        mode = 3'd2;
        for (int i = 0; i < 3; i++) tick("shl");
        #3 clear = 1'b0;
        #1;
        model_clear();
        check_all("clear_mid", m_q);
        tick("clear_held");
        #2 clear = 1'b1;

        drive(1'b1, 1'b1, 3'd1, 8'h55, 1'b0);
        tick("load_55");
        mode = 3'd6;
        tick("inv");
        mode = 3'd7;
        tick("rsvd");
        drive(1'b1, 1'b0, 3'd2, 8'h00, 1'b1);
        tick("en_off");
        check("inv_hold_const", {24'b0, Q}, 32'hAA);

        for (int i = 0; i < 300; i++) begin
            drive($urandom_range(0, 19) != 0, $urandom_range(0, 9) != 0,
                  3'($urandom_range(0, 7)), 8'($urandom), 1'($urandom_range(0, 1)));
            tick("rand");
            if ($urandom_range(0, 39) == 0) begin
                #2 clear = 1'b0;
                #1;
                model_clear();
                check_all("rand_clear", m_q);
                #1 clear = 1'b1;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
